// File: rtl/fetch_seq_pkg.sv
// Shared types and default constants for the fetch sequencer.
//   state_t         : sequencer FSM states
//   *_DEF constants : default parameter values for fetch_sequencer
package fetch_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PC_W_DEF         = 32;
  localparam int INSTR_STEP_DEF   = 1;
  localparam int DRAIN_CYCLES_DEF = 2;
  localparam int CNT_W_DEF        = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the count (wins over en)
//   en         : increment by one, sticking at all-ones
//   count      : current value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clear)
      count <= '0;
    else if (en && (count != '1))
      count <= count + W'(1);
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control: picks the PC register's next value (hold / step / branch
// redirect / program start), runs the start/done handshake, drains the
// pipeline on halt and keeps cycle and fetch counters.
//   clk, reset            : clock, synchronous active-high reset
//   start, start_pc       : program launch, accepted only in IDLE
//   pc_q                  : PC register output fed back
//   stall                 : decode hazard hold
//   branch_taken/_target  : execute redirect
//   halt                  : halt instruction decoded
//   next_pc               : PC register D input (combinational)
//   fetch_valid, flush    : fetch qualifier / younger-instruction squash
//   busy, done            : RUN|DRAIN indicator, one-cycle end pulse
//   cycle_count           : RUN + DRAIN cycles
//   fetch_count           : valid RUN fetches
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int PC_W         = PC_W_DEF,
  parameter int INSTR_STEP   = INSTR_STEP_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  start_pc,
  input  logic [PC_W-1:0]  pc_q,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt,
  output logic [PC_W-1:0]  next_pc,
  output logic             fetch_valid,
  output logic             flush,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] fetch_count
);

  // Drain counter needs at least one bit even when DRAIN_CYCLES is 0 or 1.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;

  state_t        state;
  logic [DW-1:0] drain_cnt;

  // Next-PC mux; branch outranks stall since it resolves in an older stage.
  always_comb begin
    next_pc     = pc_q;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    if (reset) begin
      next_pc = '0;
    end else begin
      case (state)
        IDLE: if (start) next_pc = start_pc;
        RUN: begin
          if (halt) begin
            fetch_valid = 1'b0;
          end else if (branch_taken) begin
            next_pc = branch_target;
            flush   = 1'b1;
          end else if (stall) begin
            fetch_valid = 1'b0;
          end else begin
            next_pc     = pc_q + PC_W'(INSTR_STEP);
            fetch_valid = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= RUN;
        RUN: begin
          if (halt) begin
            if (DRAIN_CYCLES == 0) begin
              state <= DONE;
            end else begin
              state     <= DRAIN;
              drain_cnt <= DW'(DRAIN_CYCLES);
            end
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt - DW'(1);
          // <= guards against a stray zero count stranding the FSM
          if (drain_cnt <= DW'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = !reset && ((state == RUN) || (state == DRAIN));
  assign done = !reset && (state == DONE);

  logic cnt_clear;
  assign cnt_clear = !reset && (state == IDLE) && start;

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    (busy),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .en    ((state == RUN) && fetch_valid),
    .count (fetch_count)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. Three instances share the control
// inputs: u_d (defaults), u_z (DRAIN_CYCLES=0), u_e (PC_W=8, CNT_W=4).
// Each has its own PC register model. Expected values are pushed to a
// scoreboard queue as stimulus is driven and popped as outputs are sampled.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, stall, branch_taken, halt;
  logic [31:0] start_pc, branch_target;

  logic [31:0] pc_d, np_d, cc_d, fc_d;
  logic        fv_d, fl_d, busy_d, done_d;
  logic [31:0] pc_z, np_z, cc_z, fc_z;
  logic        fv_z, fl_z, busy_z, done_z;
  logic [7:0]  pc_e, np_e;
  logic [3:0]  cc_e, fc_e;
  logic        fv_e, fl_e, busy_e, done_e;

  always @(posedge clk) begin
    pc_d <= np_d;
    pc_z <= np_z;
    pc_e <= np_e;
  end

  fetch_sequencer u_d (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .pc_q(pc_d),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .next_pc(np_d), .fetch_valid(fv_d), .flush(fl_d),
    .busy(busy_d), .done(done_d), .cycle_count(cc_d), .fetch_count(fc_d)
  );

  fetch_sequencer #(.DRAIN_CYCLES(0)) u_z (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .pc_q(pc_z),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt(halt), .next_pc(np_z), .fetch_valid(fv_z), .flush(fl_z),
    .busy(busy_z), .done(done_z), .cycle_count(cc_z), .fetch_count(fc_z)
  );

  fetch_sequencer #(.PC_W(8), .CNT_W(4)) u_e (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc[7:0]), .pc_q(pc_e),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target[7:0]),
    .halt(halt), .next_pc(np_e), .fetch_valid(fv_e), .flush(fl_e),
    .busy(busy_e), .done(done_e), .cycle_count(cc_e), .fetch_count(fc_e)
  );

  int          total = 0;
  int          bad   = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic push(input string t, input logic [63:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic chk(input logic [63:0] obs);
    string       t;
    logic [63:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    start_pc = '0; branch_target = '0;

    // Outputs forced quiet while reset is high, even with requests present.
    tick();
    start = 1'b1; start_pc = 32'h40; branch_taken = 1'b1; branch_target = 32'h99;
    push("rst_next_pc", 0); push("rst_flush", 0); push("rst_fv", 0);
    push("rst_busy", 0); push("rst_done", 0);
    settle();
    chk(np_d); chk(fl_d); chk(fv_d); chk(busy_d); chk(done_d);
    tick();
    reset = 1'b0; start = 1'b0; branch_taken = 1'b0;
    push("idle_busy", 0); push("idle_cycles", 0); push("idle_fetches", 0);
    push("idle_hold", 0); push("idle_fv", 0);
    settle();
    chk(busy_d); chk(cc_d); chk(fc_d); chk(np_d); chk(fv_d);

    // Start at 0x40, sequential fetch.
    tick();
    start = 1'b1; start_pc = 32'h40;
    push("start_next_pc", 32'h40); push("start_busy_low", 0);
    settle();
    chk(np_d); chk(busy_d);
    tick();
    start = 1'b0;
    push("run_pc40", 32'h40); push("run_fv", 1); push("run_busy", 1);
    push("run_next_pc", 32'h41); push("run_cycles0", 0);
    settle();
    chk(pc_d); chk(fv_d); chk(busy_d); chk(np_d); chk(cc_d);
    tick();
    push("run_pc41", 32'h41); push("run_fv41", 1);
    settle();
    chk(pc_d); chk(fv_d);

    // Plain branch to 0x10.
    tick();
    branch_taken = 1'b1; branch_target = 32'h10;
    push("run_pc42", 32'h42); push("cycles2", 2); push("fetches2", 2);
    push("br_flush", 1); push("br_fv", 0); push("br_next_pc", 32'h10);
    settle();
    chk(pc_d); chk(cc_d); chk(fc_d); chk(fl_d); chk(fv_d); chk(np_d);

    // Branch and stall together: branch wins.
    tick();
    stall = 1'b1; branch_target = 32'h80;
    push("br_pc10", 32'h10); push("brst_next_pc", 32'h80); push("brst_flush", 1);
    push("brst_fv", 0); push("brst_fetches", 2); push("brst_cycles", 3);
    settle();
    chk(pc_d); chk(np_d); chk(fl_d); chk(fv_d); chk(fc_d); chk(cc_d);
    tick();
    stall = 1'b0; branch_target = 32'h20;
    push("br_pc80", 32'h80); push("fetches_after_br", 2); push("cycles4", 4);
    settle();
    chk(pc_d); chk(fc_d); chk(cc_d);

    // Three stall cycles at 0x20.
    tick();
    branch_taken = 1'b0; stall = 1'b1;
    push("stall_pc", 32'h20); push("stall_next_pc", 32'h20); push("stall_fv", 0);
    push("stall_flush", 0); push("stall_cycles", 5);
    settle();
    chk(pc_d); chk(np_d); chk(fv_d); chk(fl_d); chk(cc_d);
    for (int i = 0; i < 2; i++) begin
      tick();
      push("stall_pc_hold", 32'h20); push("stall_fv_hold", 0);
      settle();
      chk(pc_d); chk(fv_d);
    end
    tick();
    stall = 1'b0;
    push("unstall_pc", 32'h20); push("unstall_fv", 1); push("unstall_next_pc", 32'h21);
    push("stall_cycles_total", 8); push("stall_fetches", 2);
    settle();
    chk(pc_d); chk(fv_d); chk(np_d); chk(cc_d); chk(fc_d);

    // Halt at 0x21 (cycle k).
    tick();
    halt = 1'b1;
    push("halt_pc", 32'h21); push("halt_fetches", 3); push("halt_cycles", 9);
    push("halt_next_pc", 32'h21); push("halt_fv", 0); push("halt_busy", 1);
    push("z_halt_next_pc", 32'h21); push("z_halt_done", 0);
    settle();
    chk(pc_d); chk(fc_d); chk(cc_d); chk(np_d); chk(fv_d); chk(busy_d);
    chk(np_z); chk(done_z);
    // k+1: requests in DRAIN/DONE must be ignored, start included.
    tick();
    halt = 1'b0; branch_taken = 1'b1; branch_target = 32'h99; stall = 1'b1;
    start = 1'b1; start_pc = 32'h77;
    push("drain_busy", 1); push("drain_done", 0); push("drain_next_pc", 32'h21);
    push("drain_flush", 0); push("drain_fv", 0); push("drain_cycles", 10);
    push("z_done_k1", 1); push("z_busy_k1", 0); push("z_done_next_pc", 32'h21);
    push("z_cycles_k1", 10);
    settle();
    chk(busy_d); chk(done_d); chk(np_d); chk(fl_d); chk(fv_d); chk(cc_d);
    chk(done_z); chk(busy_z); chk(np_z); chk(cc_z);
    tick();
    branch_taken = 1'b0; stall = 1'b0; start = 1'b0;
    push("drain2_busy", 1); push("drain2_done", 0); push("drain2_pc", 32'h21);
    push("drain2_cycles", 11); push("z_idle_done", 0); push("z_idle_busy", 0);
    push("z_held_cycles", 10); push("z_held_fetches", 3); push("z_pc", 32'h21);
    settle();
    chk(busy_d); chk(done_d); chk(pc_d); chk(cc_d);
    chk(done_z); chk(busy_z); chk(cc_z); chk(fc_z); chk(pc_z);
    tick();
    push("done_pulse", 1); push("done_busy", 0); push("done_cycles", 12);
    push("done_fetches", 3); push("done_pc", 32'h21); push("e_done_pulse", 1);
    settle();
    chk(done_d); chk(busy_d); chk(cc_d); chk(fc_d); chk(pc_d); chk(done_e);
    tick();
    push("post_done_low", 0); push("post_busy", 0); push("post_cycles_held", 12);
    settle();
    chk(done_d); chk(busy_d); chk(cc_d);

    // PC wrap on the 8-bit instance and 4-bit counter saturation.
    tick();
    start = 1'b1; start_pc = 32'hFF;
    push("e_start_next_pc", 8'hFF);
    settle();
    chk(np_e);
    tick();
    start = 1'b0;
    push("e_pc_ff", 8'hFF); push("e_wrap_next_pc", 8'h00); push("d_no_wrap", 32'h100);
    push("e_cycles_clear", 0); push("e_fv", 1);
    settle();
    chk(pc_e); chk(np_e); chk(np_d); chk(cc_e); chk(fv_e);
    for (int i = 0; i < 20; i++) tick();
    push("e_cycles_sat", 4'hF); push("e_fetches_sat", 4'hF); push("d_cycles20", 20);
    push("e_pc_wrapped", 8'h13); push("d_pc", 32'h113);
    settle();
    chk(cc_e); chk(fc_e); chk(cc_d); chk(pc_e); chk(pc_d);

    // Reset in the middle of DRAIN.
    tick();
    halt = 1'b1;
    settle();
    tick();
    halt = 1'b0; reset = 1'b1;
    push("rd_next_pc", 0); push("rd_busy", 0); push("rd_done", 0);
    push("rd_z_done", 0); push("rd_fv", 0);
    settle();
    chk(np_d); chk(busy_d); chk(done_d); chk(done_z); chk(fv_d);
    tick();
    reset = 1'b0;
    push("rd_idle_busy", 0); push("rd_idle_done", 0); push("rd_cycles0", 0);
    push("rd_fetches0", 0); push("rd_z_done_after", 0);
    settle();
    chk(busy_d); chk(done_d); chk(cc_d); chk(fc_d); chk(done_z);
    tick();
    push("rd_no_done", 0); push("rd_still_idle", 0);
    settle();
    chk(done_d); chk(busy_d);

    // Normal restart at 0x5.
    tick();
    start = 1'b1; start_pc = 32'h5;
    push("rs_next_pc", 32'h5);
    settle();
    chk(np_d);
    tick();
    start = 1'b0;
    push("rs_pc", 32'h5); push("rs_fv", 1); push("rs_busy", 1); push("rs_next", 32'h6);
    settle();
    chk(pc_d); chk(fv_d); chk(busy_d); chk(np_d);
    tick();
    push("rs_pc6", 32'h6); push("rs_cycles1", 1); push("rs_fetches1", 1);
    settle();
    chk(pc_d); chk(cc_d); chk(fc_d);

    if (exp_q.size() != 0) begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
